reg32_byte_reader: RTL
======================

// Module: reg32_byte_reader
// PURPOSE
//  Read-out side of the 8-bit register datapath. Accepts one 32-bit word per
//  valid/ready transfer and returns it as a stream of four 8-bit bytes, one
//  byte per accepted output beat. Sits between 32-bit register storage and
//  8-bit consumers such as byte buses and serial links.
// PARAMETERS
//  WORD_W     32  input word width; must be a multiple of BYTE_W
//  BYTE_W      8  output byte width
//  MSB_FIRST   0  0: emit byte[0] (bits 7:0) first; 1: emit top byte first
//  (derived) NB = WORD_W/BYTE_W = 4 beats per word; IDX_W = clog2(NB) = 2
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       in_data holds a word to be read out
//  in_ready   out  1       block will accept in_data this cycle
//  in_data    in   WORD_W  word to unpack
//  out_valid  out  1       out_data holds a valid byte
//  out_ready  in   1       consumer accepts out_data this cycle
//  out_data   out  BYTE_W  current byte
//  out_last   out  1       current byte is the final byte of its word
//  busy       out  1       a word is held (state SEND)
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, idx=0, hold=0. Outputs
//    out_valid=0, out_last=0, out_data=0, busy=0, in_ready=1.
//    Reset wins over every other event in the same cycle. A word that is
//    mid-readout is discarded and no further bytes of it are emitted.
//  - Registers: hold[WORD_W-1:0], idx[IDX_W-1:0], state {IDLE, SEND}.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - IDLE: in_ready=1, out_valid=0. On in_fire: hold<=in_data, idx<=0,
//    state<=SEND.
//  - SEND: out_valid=1, busy=1. out_data = hold slice sel, where
//    sel = idx when MSB_FIRST=0 and sel = NB-1-idx when MSB_FIRST=1;
//    slice = hold[sel*BYTE_W +: BYTE_W]. out_last = (idx==NB-1).
//    - out_fire & !out_last: idx<=idx+1.
//    - out_fire & out_last: if in_fire, hold<=in_data, idx<=0 and state stays
//      SEND; otherwise state<=IDLE and idx<=0.
//    - no out_fire: all state is held, and out_data/out_last stay stable.
//  - in_ready = (state==IDLE) | (state==SEND & out_last & out_ready). This is
//    a combinational path from out_ready and gives zero-bubble back-to-back
//    words.
//  - Latency: first byte is valid 1 cycle after in_fire. Sustained
//    throughput is 1 byte/cycle with out_ready held high, i.e. 4 cycles/word.
//  - out_data is 0 whenever out_valid=0; in IDLE, hold is not driven out.
//  - in_data is ignored when in_fire=0, and in_valid in SEND is not
//    consumed before the last beat.
//  - idx wraps only via an explicit reset to 0 on the last beat; it never
//    free-runs past NB-1.
// TESTING
//  1 Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, busy=0,
//    in_ready=1, out_data=0; no word captured.
//  2 Single word, MSB_FIRST=0, in_data=32'hA1B2C3D4, out_ready=1 ->
//    bytes D4,C3,B2,A1 on 4 consecutive cycles; out_last only on A1; IDLE after.
//  3 Same word, MSB_FIRST=1 -> bytes A1,B2,C3,D4 in that order; out_last on D4.
//  4 Backpressure: out_ready low on beats 2-3 for 3 cycles -> out_data holds
//    C3 and idx frozen; sequence resumes without loss or duplication.
//  5 Back-to-back: words 32'h11223344 then 32'h55667788 with in_valid held,
//    out_ready=1 -> 8 contiguous beats 44,33,22,11,88,77,66,55;
//    in_ready pulses high on beat 4.
//  6 Reset mid-word: assert reset after 2 of 4 beats -> next cycle
//    out_valid=0, busy=0; the next word starts at byte 0.

Source files
------------

// File: rtl/reg32_byte_reader_if.sv
// Handshake bundle between the 32-bit word producer, the byte reader and the
// 8-bit consumer. The master side drives words in and accepts bytes out.
interface reg32_byte_reader_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BYTE_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/reg32_byte_reader.sv
// Word-to-byte unpacker: captures one WORD_W word per input transfer and
// emits it as NB bytes, low byte first (or high byte first with MSB_FIRST).
module reg32_byte_reader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned BYTE_W    = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic               clk,
  input logic               reset,
  reg32_byte_reader_if.slave bus
);
  localparam int unsigned NB    = WORD_W / BYTE_W;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [IDX_W-1:0]    sel;
  logic [BYTE_W-1:0]   slice;
  logic                out_valid, out_last, in_ready;
  logic                in_fire, out_fire;
  logic [BYTE_W-1:0]   out_data;

  // State register; reset discards any word being read out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
    end
  end

  // Byte select, handshake outputs and next-state decode.
  always_comb begin
    sel = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
    slice = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (sel == IDX_W'(b)) slice = hold_q[b*BYTE_W +: BYTE_W];
    end

    out_valid = (state_q == SEND);
    out_last  = out_valid && (idx_q == LAST_IDX);
    out_data  = out_valid ? slice : '0;
    // Accepting on the last beat lets the next word follow with no bubble.
    in_ready  = !out_valid || (out_last && bus.out_ready);
    in_fire   = bus.in_valid && in_ready;
    out_fire  = out_valid && bus.out_ready;

    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          hold_d  = bus.in_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (!out_last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = '0;
            if (in_fire) hold_d = bus.in_data;
            else         state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = out_data;
  assign bus.in_ready  = in_ready;
  assign bus.busy      = out_valid;
endmodule
